// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the system controller slice.
//   - command codes recognised in IDLE
//   - controller state encoding (also used by the TX handshake sequencer)
//   - nb_bytes(): number of DATA_WIDTH bytes needed to carry an ALU result
package sys_ctrl_pkg;

   localparam logic [7:0] CMD_WR      = 8'hAA;
   localparam logic [7:0] CMD_RD      = 8'hBB;
   localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
   localparam logic [7:0] CMD_ALU_NOP = 8'hDD;
   localparam logic [7:0] CMD_BWR     = 8'hEE;
   localparam logic [7:0] CMD_BRD     = 8'hEF;

   typedef enum logic [4:0] {
      IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT,
      ALU_A, ALU_B, ALU_FUN_S, ALU_WAIT,
      BW_ADDR, BW_CNT, BW_DATA, BR_ADDR, BR_CNT,
      TX_SEND, TX_WAIT_H, TX_WAIT_L
   } state_e;

   function automatic int unsigned nb_bytes(input int unsigned out_w,
                                            input int unsigned data_w);
      return (out_w + data_w - 1) / data_w;
   endfunction

endpackage

// File: rtl/ctrl_tx_seq.sv
// Byte-serialiser for the UART TX side.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   load              one-cycle request to start sending word/nbytes
//   word              NB bytes to send, least significant byte first
//   nbytes            number of bytes of word to send (1..NB)
//   tx_busy           UART transmitter busy
//   tx_data, tx_vld   byte and one-cycle request towards the transmitter
//   done              one-cycle pulse once the last byte has been accepted
module ctrl_tx_seq
   import sys_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned NB         = 2,
   parameter int unsigned CNT_W      = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     load,
   input  logic [NB*DATA_WIDTH-1:0] word,
   input  logic [CNT_W-1:0]         nbytes,
   input  logic                     tx_busy,
   output logic [DATA_WIDTH-1:0]    tx_data,
   output logic                     tx_vld,
   output logic                     done
);

   state_e                    st_q, st_n;
   logic [NB*DATA_WIDTH-1:0]  word_q, word_n;
   logic [CNT_W-1:0]          rem_q, rem_n;
   logic                      vld_q, vld_n;
   logic                      done_q, done_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q   <= IDLE;
         word_q <= '0;
         rem_q  <= '0;
         vld_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         st_q   <= st_n;
         word_q <= word_n;
         rem_q  <= rem_n;
         vld_q  <= vld_n;
         done_q <= done_n;
      end
   end

   always_comb begin
      st_n   = st_q;
      word_n = word_q;
      rem_n  = rem_q;
      vld_n  = 1'b0;
      done_n = 1'b0;
      case (st_q)
         IDLE: if (load) begin
            word_n = word;
            rem_n  = nbytes;
            st_n   = TX_SEND;
         end
         TX_SEND: if (!tx_busy) begin
            vld_n = 1'b1;
            st_n  = TX_WAIT_H;
         end
         TX_WAIT_H: if (tx_busy) st_n = TX_WAIT_L;
         TX_WAIT_L: if (!tx_busy) begin
            if (rem_q > CNT_W'(1)) begin
               // current byte always sits in the low lane of word_q
               rem_n  = rem_q - CNT_W'(1);
               word_n = word_q >> DATA_WIDTH;
               st_n   = TX_SEND;
            end else begin
               rem_n  = '0;
               done_n = 1'b1;
               st_n   = IDLE;
            end
         end
         default: st_n = IDLE;
      endcase
   end

   assign tx_data = word_q[DATA_WIDTH-1:0];
   assign tx_vld  = vld_q;
   assign done    = done_q;

endmodule

// File: rtl/sys_ctrl_burst.sv
// System controller: parses framed UART commands, drives register file and
// ALU control, and returns results through the UART TX handshake.
// Commands: AA write, BB read, CC ALU with operands, DD ALU only,
//           EE burst write, EF burst read (addresses wrap at 2^ADDR_WIDTH).
// Ports:
//   CLK, RST                          clock, asynchronous active-low reset
//   UART_RX_DATA/VLD                  incoming byte stream
//   ALU_OUT/VLD, RF_RdData/VLD        results from ALU and register file
//   UART_TX_Busy                      transmitter busy
//   ALU_EN/FUN, CLKG_EN, CLKDIV_EN    ALU and clocking control
//   RF_Address/WrEn/RdEn/WrData       register file access
//   UART_TX_DATA/VLD                  outgoing byte request
//   ERR_FLAG                          one-cycle pulse on a dropped byte
module sys_ctrl_burst
   import sys_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned ADDR_WIDTH    = 4,
   parameter int unsigned ALU_FUN_WIDTH = 4,
   parameter int unsigned ALU_OUT_WIDTH = 16
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [DATA_WIDTH-1:0]    UART_RX_DATA,
   input  logic                     UART_RX_VLD,
   input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
   input  logic                     ALU_OUT_VLD,
   input  logic [DATA_WIDTH-1:0]    RF_RdData,
   input  logic                     RF_RdData_VLD,
   input  logic                     UART_TX_Busy,
   output logic                     ALU_EN,
   output logic [ALU_FUN_WIDTH-1:0] ALU_FUN,
   output logic                     CLKG_EN,
   output logic                     CLKDIV_EN,
   output logic [ADDR_WIDTH-1:0]    RF_Address,
   output logic                     RF_WrEn,
   output logic                     RF_RdEn,
   output logic [DATA_WIDTH-1:0]    RF_WrData,
   output logic [DATA_WIDTH-1:0]    UART_TX_DATA,
   output logic                     UART_TX_VLD,
   output logic                     ERR_FLAG
);

   localparam int unsigned NB    = nb_bytes(ALU_OUT_WIDTH, DATA_WIDTH);
   localparam int unsigned CNT_W = $clog2(NB + 1);

   state_e                   state_q, state_n;
   logic [ADDR_WIDTH-1:0]    addr_q, addr_n;
   logic [DATA_WIDTH-1:0]    cnt_q, cnt_n;
   logic                     alu_pend_q, alu_pend_n;
   logic                     alu_en_q, alu_en_n;
   logic [ALU_FUN_WIDTH-1:0] alu_fun_q, alu_fun_n;
   logic                     clkg_q, clkg_n;
   logic                     clkdiv_q;
   logic [ADDR_WIDTH-1:0]    rf_addr_q, rf_addr_n;
   logic                     wren_q, wren_n;
   logic                     rden_q, rden_n;
   logic [DATA_WIDTH-1:0]    wrdata_q, wrdata_n;
   logic                     err_q, err_n;

   logic                     tx_load, tx_done;
   logic [NB*DATA_WIDTH-1:0] tx_word;
   logic [CNT_W-1:0]         tx_nb;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         cnt_q      <= '0;
         alu_pend_q <= 1'b0;
         alu_en_q   <= 1'b0;
         alu_fun_q  <= '0;
         clkg_q     <= 1'b0;
         clkdiv_q   <= 1'b0;
         rf_addr_q  <= '0;
         wren_q     <= 1'b0;
         rden_q     <= 1'b0;
         wrdata_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_n;
         addr_q     <= addr_n;
         cnt_q      <= cnt_n;
         alu_pend_q <= alu_pend_n;
         alu_en_q   <= alu_en_n;
         alu_fun_q  <= alu_fun_n;
         clkg_q     <= clkg_n;
         clkdiv_q   <= 1'b1;
         rf_addr_q  <= rf_addr_n;
         wren_q     <= wren_n;
         rden_q     <= rden_n;
         wrdata_q   <= wrdata_n;
         err_q      <= err_n;
      end
   end

   always_comb begin
      state_n    = state_q;
      addr_n     = addr_q;
      cnt_n      = cnt_q;
      alu_pend_n = alu_pend_q;
      alu_en_n   = 1'b0;
      alu_fun_n  = alu_fun_q;
      clkg_n     = clkg_q;
      rf_addr_n  = rf_addr_q;
      wren_n     = 1'b0;
      rden_n     = 1'b0;
      wrdata_n   = wrdata_q;
      err_n      = 1'b0;
      tx_load    = 1'b0;
      tx_word    = '0;
      tx_nb      = '0;
      case (state_q)
         IDLE: if (UART_RX_VLD) begin
            case (UART_RX_DATA)
               DATA_WIDTH'(CMD_WR):      state_n = WR_ADDR;
               DATA_WIDTH'(CMD_RD):      state_n = RD_ADDR;
               DATA_WIDTH'(CMD_ALU_OP):  state_n = ALU_A;
               DATA_WIDTH'(CMD_ALU_NOP): state_n = ALU_FUN_S;
               DATA_WIDTH'(CMD_BWR):     state_n = BW_ADDR;
               DATA_WIDTH'(CMD_BRD):     state_n = BR_ADDR;
               default:                  err_n   = 1'b1;
            endcase
         end
         WR_ADDR: if (UART_RX_VLD) begin
            addr_n  = UART_RX_DATA[ADDR_WIDTH-1:0];
            state_n = WR_DATA;
         end
         WR_DATA: if (UART_RX_VLD) begin
            wren_n    = 1'b1;
            rf_addr_n = addr_q;
            wrdata_n  = UART_RX_DATA;
            state_n   = IDLE;
         end
         RD_ADDR: if (UART_RX_VLD) begin
            addr_n    = UART_RX_DATA[ADDR_WIDTH-1:0];
            cnt_n     = '0;
            rden_n    = 1'b1;
            rf_addr_n = UART_RX_DATA[ADDR_WIDTH-1:0];
            state_n   = RD_WAIT;
         end
         RD_WAIT: begin
            err_n = UART_RX_VLD;
            if (RF_RdData_VLD) begin
               tx_load                   = 1'b1;
               tx_word[DATA_WIDTH-1:0]   = RF_RdData;
               tx_nb                     = CNT_W'(1);
               state_n                   = TX_SEND;
            end
         end
         ALU_A: if (UART_RX_VLD) begin
            wren_n    = 1'b1;
            rf_addr_n = '0;
            wrdata_n  = UART_RX_DATA;
            state_n   = ALU_B;
         end
         ALU_B: if (UART_RX_VLD) begin
            wren_n    = 1'b1;
            rf_addr_n = ADDR_WIDTH'(1);
            wrdata_n  = UART_RX_DATA;
            state_n   = ALU_FUN_S;
         end
         ALU_FUN_S: if (UART_RX_VLD) begin
            alu_fun_n  = UART_RX_DATA[ALU_FUN_WIDTH-1:0];
            clkg_n     = 1'b1;
            alu_pend_n = 1'b1;
            state_n    = ALU_WAIT;
         end
         ALU_WAIT: begin
            err_n = UART_RX_VLD;
            // first cycle in ALU_WAIT fires ALU_EN; a result is only taken after that
            if (alu_pend_q) begin
               alu_en_n   = 1'b1;
               alu_pend_n = 1'b0;
            end else if (ALU_OUT_VLD) begin
               tx_load                    = 1'b1;
               tx_word[ALU_OUT_WIDTH-1:0] = ALU_OUT;
               tx_nb                      = CNT_W'(NB);
               clkg_n                     = 1'b0;
               state_n                    = TX_SEND;
            end
         end
         BW_ADDR, BR_ADDR: if (UART_RX_VLD) begin
            addr_n  = UART_RX_DATA[ADDR_WIDTH-1:0];
            state_n = (state_q == BW_ADDR) ? BW_CNT : BR_CNT;
         end
         BW_CNT: if (UART_RX_VLD) begin
            cnt_n   = UART_RX_DATA;
            state_n = (UART_RX_DATA == '0) ? IDLE : BW_DATA;
         end
         BW_DATA: if (UART_RX_VLD) begin
            wren_n    = 1'b1;
            rf_addr_n = addr_q;
            wrdata_n  = UART_RX_DATA;
            addr_n    = addr_q + ADDR_WIDTH'(1);
            cnt_n     = cnt_q - DATA_WIDTH'(1);
            if (cnt_q == DATA_WIDTH'(1)) state_n = IDLE;
         end
         BR_CNT: if (UART_RX_VLD) begin
            cnt_n = UART_RX_DATA;
            if (UART_RX_DATA == '0) begin
               state_n = IDLE;
            end else begin
               rden_n    = 1'b1;
               rf_addr_n = addr_q;
               state_n   = RD_WAIT;
            end
         end
         // The byte handshake itself lives in ctrl_tx_seq; the controller parks
         // in TX_SEND until it reports done, then chains the next burst read.
         TX_SEND: begin
            err_n = UART_RX_VLD;
            if (tx_done) begin
               if (cnt_q > DATA_WIDTH'(1)) begin
                  cnt_n     = cnt_q - DATA_WIDTH'(1);
                  addr_n    = addr_q + ADDR_WIDTH'(1);
                  rden_n    = 1'b1;
                  rf_addr_n = addr_q + ADDR_WIDTH'(1);
                  state_n   = RD_WAIT;
               end else begin
                  cnt_n   = '0;
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   ctrl_tx_seq #(
      .DATA_WIDTH (DATA_WIDTH),
      .NB         (NB),
      .CNT_W      (CNT_W)
   ) u_tx_seq (
      .clk     (CLK),
      .rst_n   (RST),
      .load    (tx_load),
      .word    (tx_word),
      .nbytes  (tx_nb),
      .tx_busy (UART_TX_Busy),
      .tx_data (UART_TX_DATA),
      .tx_vld  (UART_TX_VLD),
      .done    (tx_done)
   );

   assign ALU_EN     = alu_en_q;
   assign ALU_FUN    = alu_fun_q;
   assign CLKG_EN    = clkg_q;
   assign CLKDIV_EN  = clkdiv_q;
   assign RF_Address = rf_addr_q;
   assign RF_WrEn    = wren_q;
   assign RF_RdEn    = rden_q;
   assign RF_WrData  = wrdata_q;
   assign ERR_FLAG   = err_q;

endmodule

// File: tb/tb_sys_ctrl_burst.sv
// Directed bench for sys_ctrl_burst with small register-file, ALU and UART
// transmitter responders.
module tb_sys_ctrl_burst;

   logic        CLK = 1'b0;
   logic        RST;
   logic [7:0]  UART_RX_DATA = '0;
   logic        UART_RX_VLD = 1'b0;
   logic [15:0] ALU_OUT = '0;
   logic        ALU_OUT_VLD = 1'b0;
   logic [7:0]  RF_RdData = '0;
   logic        RF_RdData_VLD = 1'b0;
   logic        UART_TX_Busy = 1'b0;
   logic        ALU_EN;
   logic [3:0]  ALU_FUN;
   logic        CLKG_EN, CLKDIV_EN;
   logic [3:0]  RF_Address;
   logic        RF_WrEn, RF_RdEn;
   logic [7:0]  RF_WrData, UART_TX_DATA;
   logic        UART_TX_VLD, ERR_FLAG;

   always #5 CLK = ~CLK;

   sys_ctrl_burst #(
      .DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_FUN_WIDTH(4), .ALU_OUT_WIDTH(16)
   ) dut (
      .CLK(CLK), .RST(RST),
      .UART_RX_DATA(UART_RX_DATA), .UART_RX_VLD(UART_RX_VLD),
      .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
      .RF_RdData(RF_RdData), .RF_RdData_VLD(RF_RdData_VLD),
      .UART_TX_Busy(UART_TX_Busy),
      .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLKG_EN(CLKG_EN), .CLKDIV_EN(CLKDIV_EN),
      .RF_Address(RF_Address), .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn),
      .RF_WrData(RF_WrData), .UART_TX_DATA(UART_TX_DATA), .UART_TX_VLD(UART_TX_VLD),
      .ERR_FLAG(ERR_FLAG)
   );

   int unsigned n_chk = 0, n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // observation state
   int          cyc = 0;
   logic [11:0] wr_q[$];
   logic [7:0]  tx_q[$];
   logic [7:0]  rf_mem [16];
   int          err_cnt = 0, rd_cnt = 0, b2b = 0, busy_viol = 0;
   int          wr_cyc = 0, last_rx_cyc = 0;
   int          clkg_rise = 0, clkg_fall = 0, alu_en_cyc = 0, alu_vld_cyc = 0;
   logic [3:0]  alu_fun_seen = '0;
   logic        clkg_prev = 1'b0;
   logic [4:0]  pulses_prev = '0;
   int          rd_tmr = 0, alu_tmr = 0, tx_ph = 0;
   logic [3:0]  rd_addr = '0;

   always @(posedge CLK) cyc++;

   always @(negedge CLK) begin
      logic [4:0] pulses;
      // responders driven from earlier requests
      if (RF_RdData_VLD) RF_RdData_VLD = 1'b0;
      else if (rd_tmr != 0) begin
         rd_tmr--;
         if (rd_tmr == 0) begin RF_RdData = rf_mem[rd_addr]; RF_RdData_VLD = 1'b1; end
      end
      if (ALU_OUT_VLD) ALU_OUT_VLD = 1'b0;
      else if (alu_tmr != 0) begin
         alu_tmr--;
         if (alu_tmr == 0) begin
            ALU_OUT = 16'(rf_mem[0]) + 16'(rf_mem[1]);
            ALU_OUT_VLD = 1'b1;
            alu_vld_cyc = cyc;
         end
      end
      // monitor DUT outputs
      if (RF_WrEn) begin
         wr_q.push_back({RF_Address, RF_WrData});
         rf_mem[RF_Address] = RF_WrData;
         wr_cyc = cyc;
      end
      if (RF_RdEn) begin rd_cnt++; rd_addr = RF_Address; rd_tmr = 2; end
      if (ALU_EN) begin alu_en_cyc = cyc; alu_fun_seen = ALU_FUN; alu_tmr = 3; end
      if (ERR_FLAG) err_cnt++;
      if (CLKG_EN && !clkg_prev) clkg_rise = cyc;
      if (!CLKG_EN && clkg_prev) clkg_fall = cyc;
      clkg_prev = CLKG_EN;
      pulses = {RF_WrEn, RF_RdEn, ALU_EN, UART_TX_VLD, ERR_FLAG};
      if ((pulses & pulses_prev) != '0) b2b++;
      pulses_prev = pulses;
      // transmitter: busy goes high 3 cycles after a request, for 6 cycles
      if (UART_TX_VLD) begin
         if (UART_TX_Busy) busy_viol++;
         tx_q.push_back(UART_TX_DATA);
         tx_ph = 9;
      end else if (tx_ph != 0) tx_ph--;
      UART_TX_Busy = (tx_ph != 0) && (tx_ph <= 6);
   end

   function automatic logic [31:0] out_vec();
      return {1'b0, ALU_EN, ALU_FUN, CLKG_EN, CLKDIV_EN, RF_Address, RF_WrEn, RF_RdEn,
              RF_WrData, UART_TX_DATA, UART_TX_VLD, ERR_FLAG};
   endfunction

   function automatic logic [31:0] wr_at(input int i);
      if (i < wr_q.size()) return 32'(wr_q[i]);
      return 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] tx_at(input int i);
      if (i < tx_q.size()) return 32'(tx_q[i]);
      return 32'hFFFF_FFFF;
   endfunction

   task automatic send_byte(input logic [7:0] b);
      @(negedge CLK);
      UART_RX_DATA = b;
      UART_RX_VLD  = 1'b1;
      last_rx_cyc  = cyc;
      @(negedge CLK);
      UART_RX_VLD  = 1'b0;
      repeat (4) @(negedge CLK);
   endtask

   task automatic wait_tx(input int n);
      for (int i = 0; i < 600 && tx_q.size() < n; i++) @(negedge CLK);
      repeat (12) @(negedge CLK);
   endtask

   task automatic clear_logs();
      wr_q.delete();
      tx_q.delete();
      rd_cnt = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      RST = 1'b1;
      #3 RST = 1'b0;
      repeat (3) @(negedge CLK);
      check("reset_outputs", out_vec(), 32'h0);
      RST = 1'b1;
      @(negedge CLK);
      check("clkdiv_after_release", 32'(CLKDIV_EN), 32'h1);

      // single write, then readback
      clear_logs();
      send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
      check("wr_count", wr_q.size(), 1);
      check("wr_5_3c", wr_at(0), 32'h53C);
      check("wr_latency", wr_cyc - last_rx_cyc, 1);
      send_byte(8'hBB); send_byte(8'h05);
      wait_tx(1);
      check("rd_tx_count", tx_q.size(), 1);
      check("rd_tx_byte", tx_at(0), 32'h3C);
      check("rd_pulses", rd_cnt, 1);
      check("no_err_yet", err_cnt, 0);

      // ALU add with operands: 0x0A + 0x03 = 0x000D, sent LSB first
      clear_logs();
      send_byte(8'hCC); send_byte(8'h0A); send_byte(8'h03); send_byte(8'h00);
      wait_tx(2);
      check("alu_wr_count", wr_q.size(), 2);
      check("alu_wr_a", wr_at(0), 32'h00A);
      check("alu_wr_b", wr_at(1), 32'h103);
      check("clkg_rise_at_fun", clkg_rise - last_rx_cyc, 1);
      check("alu_en_after_clkg", alu_en_cyc - clkg_rise, 1);
      check("clkg_fall_after_vld", clkg_fall - alu_vld_cyc, 1);
      check("alu_fun", 32'(alu_fun_seen), 32'h0);
      check("alu_tx_count", tx_q.size(), 2);
      check("alu_tx_lsb", tx_at(0), 32'h0D);
      check("alu_tx_msb", tx_at(1), 32'h00);

      // burst write wrapping past address 15
      clear_logs();
      send_byte(8'hEE); send_byte(8'h0E); send_byte(8'h03);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      check("bw_count", wr_q.size(), 3);
      check("bw_0", wr_at(0), 32'hE11);
      check("bw_1", wr_at(1), 32'hF22);
      check("bw_2", wr_at(2), 32'h033);

      // burst read over the same wrapped range
      clear_logs();
      send_byte(8'hEF); send_byte(8'h0E); send_byte(8'h03);
      wait_tx(3);
      check("br_tx_count", tx_q.size(), 3);
      check("br_0", tx_at(0), 32'h11);
      check("br_1", tx_at(1), 32'h22);
      check("br_2", tx_at(2), 32'h33);
      check("br_reads", rd_cnt, 3);

      // zero-length burst returns to IDLE; unknown command flags an error
      clear_logs();
      send_byte(8'hEE); send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h7F);
      check("n0_no_write", wr_q.size(), 0);
      check("unknown_cmd_err", err_cnt, 1);

      // byte arriving while waiting for busy is dropped
      clear_logs();
      send_byte(8'hBB); send_byte(8'h05);
      for (int i = 0; i < 200 && tx_q.size() < 1; i++) @(negedge CLK);
      check("tx_started", tx_q.size(), 1);
      send_byte(8'h12);
      wait_tx(1);
      check("drop_err", err_cnt, 2);
      check("drop_tx_count", tx_q.size(), 1);
      check("drop_tx_byte", tx_at(0), 32'h3C);
      check("drop_no_write", wr_q.size(), 0);

      // reset in the middle of a 4-byte burst write
      clear_logs();
      send_byte(8'hEE); send_byte(8'h08); send_byte(8'h04); send_byte(8'hA1);
      check("mid_burst_wr", wr_at(0), 32'h8A1);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      check("mid_reset_outputs", out_vec(), 32'h0);
      @(negedge CLK);
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      clear_logs();
      send_byte(8'hAA); send_byte(8'h01); send_byte(8'h55);
      check("post_reset_count", wr_q.size(), 1);
      check("post_reset_wr", wr_at(0), 32'h155);

      check("no_back_to_back", b2b, 0);
      check("vld_while_busy", busy_viol, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
